// File: rtl/stream_pkg.sv
// Shared types and helpers for the operand stream path: lane-count sizing,
// collect FSM states and the speed clamp used by both feeder and register config.
package stream_pkg;

    function automatic int speed_log2(input int lanes);
        return (lanes == 1) ? 1 : $clog2(lanes);
    endfunction

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } coll_state_t;

    function automatic int clamp_speed(input int spd, input int lanes);
        return (spd > lanes - 1) ? lanes - 1 : spd;
    endfunction

endpackage

// File: rtl/stream_pack_lanebuf.sv
// Collect buffer: gathers 1..SPEED words into lanes, flags a completed group.
// Latency: completion strobe is combinational with the completing word.
// Backpressure: holds one complete group and drops o_rdy until i_out_free.
module stream_pack_lanebuf
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SPEED = 4,
    localparam int SPEED_LOG2 = speed_log2(SPEED)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPEED_LOG2-1:0] i_speed,
    input  logic [WIDTH-1:0]      i_dat,
    input  logic                  i_vld,
    input  logic                  i_last,
    output logic                  o_rdy,
    input  logic                  i_out_free,
    output logic                  o_grp_vld,
    output logic [WIDTH-1:0]      o_grp_dat [SPEED],
    output logic [SPEED-1:0]      o_grp_mask,
    output logic                  o_grp_last,
    output logic                  o_busy
);

    coll_state_t           r_state;
    logic [SPEED_LOG2-1:0] r_cnt;
    logic [SPEED_LOG2-1:0] r_spd_l;
    logic                  r_last;
    logic [WIDTH-1:0]      r_coll [SPEED];

    logic                  w_acc;
    logic                  w_done;
    logic [SPEED_LOG2-1:0] w_spd_in;
    logic [SPEED_LOG2-1:0] w_eff;

    assign w_spd_in = SPEED_LOG2'(clamp_speed(int'(i_speed), SPEED));
    assign o_rdy    = (r_state == ST_FILL);
    assign w_acc    = i_vld & o_rdy;
    // Speed is sampled only on the first word of a group.
    assign w_eff    = (r_cnt == '0) ? w_spd_in : r_spd_l;
    assign w_done   = w_acc & ((r_cnt == w_eff) | i_last);

    assign o_grp_vld  = (r_state == ST_FILL) ? (w_done & i_out_free) : i_out_free;
    assign o_grp_last = (r_state == ST_FILL) ? i_last : r_last;
    assign o_busy     = (r_cnt != '0) | (r_state == ST_HOLD);

    // In FILL the completing word bypasses the buffer so the output register sees it at t+1.
    always_comb begin
        for (int i = 0; i < SPEED; i++) begin
            o_grp_dat[i]  = ((r_state == ST_FILL) && (SPEED_LOG2'(i) == r_cnt)) ? i_dat : r_coll[i];
            o_grp_mask[i] = (i <= int'(r_cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_spd_l <= '0;
            r_last  <= 1'b0;
            for (int i = 0; i < SPEED; i++) begin
                r_coll[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_acc) begin
                        r_coll[r_cnt] <= i_dat;
                        if (r_cnt == '0) begin
                            r_spd_l <= w_spd_in;
                        end
                        if (w_done) begin
                            r_last <= i_last;
                            if (i_out_free) begin
                                r_cnt <= '0;
                            end else begin
                                r_state <= ST_HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + SPEED_LOG2'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_out_free) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: rtl/stream_pack_feeder.sv
// Packs a narrow word stream into SPEED-lane beats for the stream register.
// Latency: group-completing word at cycle t gives m_valid at t+1.
// Backpressure: one group in collect plus one in output, then s_ready drops.
module stream_pack_feeder
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SPEED = 4,
    localparam int SPEED_LOG2 = speed_log2(SPEED)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPEED_LOG2-1:0] speed,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [WIDTH-1:0]      m_data [SPEED],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_en,
    output logic                  m_last,
    output logic                  busy
);

    logic             w_out_free;
    logic             w_grp_vld;
    logic             w_grp_last;
    logic             w_coll_busy;
    logic [WIDTH-1:0] w_grp_dat [SPEED];
    logic [SPEED-1:0] w_grp_mask;

    logic [WIDTH-1:0] r_m_data [SPEED];
    logic             r_m_valid;
    logic             r_m_last;

    assign m_en       = r_m_valid & m_ready;
    assign w_out_free = ~r_m_valid | m_ready;

    stream_pack_lanebuf #(
        .WIDTH (WIDTH),
        .SPEED (SPEED)
    ) u_lanebuf (
        .clk        (clk),
        .reset      (reset),
        .i_speed    (speed),
        .i_dat      (s_data),
        .i_vld      (s_valid),
        .i_last     (s_last),
        .o_rdy      (s_ready),
        .i_out_free (w_out_free),
        .o_grp_vld  (w_grp_vld),
        .o_grp_dat  (w_grp_dat),
        .o_grp_mask (w_grp_mask),
        .o_grp_last (w_grp_last),
        .o_busy     (w_coll_busy)
    );

    // Lanes beyond the completing word are zeroed so short groups never leak stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SPEED; i++) begin
                r_m_data[i] <= '0;
            end
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_grp_vld) begin
            for (int i = 0; i < SPEED; i++) begin
                r_m_data[i] <= w_grp_mask[i] ? w_grp_dat[i] : '0;
            end
            r_m_valid <= 1'b1;
            r_m_last  <= w_grp_last;
        end else if (m_en) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < SPEED; i++) begin
            m_data[i] = r_m_data[i];
        end
    end

    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign busy    = w_coll_busy | r_m_valid;

endmodule

// File: tb/tb_stream_pack_feeder.sv
// Bench for stream_pack_feeder: vector table, directed corner sequences and a random run against a group model.
module tb_stream_pack_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] speed = 2'd0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] m_data [4];
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_en;
    logic       m_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    stream_pack_feeder #(.WIDTH(8), .SPEED(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .speed   (speed),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_en    (m_en),
        .m_last  (m_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [1:0] sp;
        logic       rdy;
        logic       e_srdy;
        logic       e_mval;
        logic       e_men;
        logic       e_mlast;
        logic [31:0] e_lanes;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic l, input logic [1:0] sp,
                                 input logic e_mval, input logic e_men, input logic e_mlast,
                                 input logic [31:0] e_lanes);
        vec_t x;
        x.v = v; x.d = d; x.l = l; x.sp = sp; x.rdy = 1'b1;
        x.e_srdy = 1'b1; x.e_mval = e_mval; x.e_men = e_men; x.e_mlast = e_mlast; x.e_lanes = e_lanes;
        return x;
    endfunction

    function automatic logic [31:0] lanes();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [1:0] sp, input logic rdy);
        @(negedge clk);
        s_valid = v; s_data = d; s_last = l; speed = sp; m_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
        reset = 1'b0;
    endtask

    // Reference model state: completed groups awaiting delivery and the group being built.
    logic [31:0] pend_l [$];
    bit          pend_last [$];
    logic [7:0]  part [4];
    int          part_n = 0;
    int          part_spd = 0;

    initial begin
        logic [31:0] exp_l;
        tbl[0]  = mkv(1, 8'h01, 0, 3, 0, 0, 0, 32'h0);
        tbl[1]  = mkv(1, 8'h02, 0, 3, 0, 0, 0, 32'h0);
        tbl[2]  = mkv(1, 8'h03, 0, 3, 0, 0, 0, 32'h0);
        tbl[3]  = mkv(1, 8'h04, 0, 3, 0, 0, 0, 32'h0);
        tbl[4]  = mkv(1, 8'h05, 0, 3, 1, 1, 0, 32'h04030201);
        tbl[5]  = mkv(1, 8'h06, 0, 3, 0, 0, 0, 32'h0);
        tbl[6]  = mkv(1, 8'h07, 0, 3, 0, 0, 0, 32'h0);
        tbl[7]  = mkv(1, 8'h08, 0, 3, 0, 0, 0, 32'h0);
        tbl[8]  = mkv(0, 8'h00, 0, 3, 1, 1, 0, 32'h08070605);
        tbl[9]  = mkv(0, 8'h00, 0, 3, 0, 0, 0, 32'h0);
        tbl[10] = mkv(1, 8'h0A, 0, 2, 0, 0, 0, 32'h0);
        tbl[11] = mkv(1, 8'h0B, 0, 2, 0, 0, 0, 32'h0);
        tbl[12] = mkv(1, 8'h0C, 1, 2, 0, 0, 0, 32'h0);
        tbl[13] = mkv(0, 8'h00, 0, 2, 1, 1, 1, 32'h000C0B0A);
        tbl[14] = mkv(1, 8'h21, 0, 1, 0, 0, 0, 32'h0);
        tbl[15] = mkv(1, 8'h22, 0, 1, 0, 0, 0, 32'h0);
        tbl[16] = mkv(1, 8'h33, 1, 3, 1, 1, 0, 32'h00002221);
        tbl[17] = mkv(0, 8'h00, 0, 3, 1, 1, 1, 32'h00000033);
        tbl[18] = mkv(0, 8'h00, 0, 3, 0, 0, 0, 32'h0);

        do_reset();
        chk("reset_mval", m_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_lanes", lanes(), 32'h0);

        for (int r = 0; r < NV; r++) begin
            drive(tbl[r].v, tbl[r].d, tbl[r].l, tbl[r].sp, tbl[r].rdy);
            chk($sformatf("tbl%0d_srdy", r), s_ready, tbl[r].e_srdy);
            chk($sformatf("tbl%0d_mval", r), m_valid, tbl[r].e_mval);
            chk($sformatf("tbl%0d_men", r), m_en, tbl[r].e_men);
            if (tbl[r].e_mval) begin
                chk($sformatf("tbl%0d_lanes", r), lanes(), tbl[r].e_lanes);
                chk($sformatf("tbl%0d_mlast", r), m_last, tbl[r].e_mlast);
            end
        end

        // speed=0: one beat per cycle, no bubbles
        for (int k = 0; k < 7; k++) begin
            drive(k < 6, 8'(8'hA0 + k), 1'b0, 2'd0, 1'b1);
            if (k == 0) chk("s0_srdy", s_ready, 1'b1);
            else begin
                exp_l = {24'h0, 8'(8'hA0 + k - 1)};
                chk($sformatf("s0_men%0d", k), m_en, 1'b1);
                chk($sformatf("s0_lanes%0d", k), lanes(), exp_l);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
        chk("s0_idle_mval", m_valid, 1'b0);

        // speed=1 with downstream stalled
        drive(1, 8'h01, 0, 2'd1, 0); chk("bp_srdy1", s_ready, 1'b1);
        drive(1, 8'h02, 0, 2'd1, 0);
        drive(1, 8'h03, 0, 2'd1, 0); chk("bp_mval", m_valid, 1'b1); chk("bp_lanes_a", lanes(), 32'h00000201);
        drive(1, 8'h04, 0, 2'd1, 0); chk("bp_srdy4", s_ready, 1'b1);
        drive(1, 8'h05, 0, 2'd1, 0); chk("bp_srdy_drop", s_ready, 1'b0); chk("bp_stable1", lanes(), 32'h00000201);
        drive(1, 8'h05, 0, 2'd1, 0); chk("bp_srdy_low", s_ready, 1'b0); chk("bp_stable2", lanes(), 32'h00000201);
        drive(1, 8'h05, 0, 2'd1, 1); chk("bp_men1", m_en, 1'b1); chk("bp_out12", lanes(), 32'h00000201);
        chk("bp_srdy_hold", s_ready, 1'b0);
        drive(1, 8'h05, 0, 2'd1, 1); chk("bp_srdy_back", s_ready, 1'b1); chk("bp_men2", m_en, 1'b1);
        chk("bp_out34", lanes(), 32'h00000403);
        drive(1, 8'h06, 0, 2'd1, 1); chk("bp_gap_mval", m_valid, 1'b0);
        drive(0, 8'h00, 0, 2'd1, 1); chk("bp_men3", m_en, 1'b1); chk("bp_out56", lanes(), 32'h00000605);
        drive(0, 8'h00, 0, 2'd1, 1); chk("bp_idle", m_valid, 1'b0);

        // mid-group speed change is ignored until the next group
        drive(1, 8'h01, 0, 2'd3, 1);
        drive(1, 8'h02, 0, 2'd3, 1);
        drive(1, 8'h03, 0, 2'd1, 1); chk("sw_no_early", m_valid, 1'b0);
        drive(1, 8'h04, 0, 2'd1, 1); chk("sw_no_early2", m_valid, 1'b0);
        drive(1, 8'h05, 0, 2'd1, 1); chk("sw_grp4", lanes(), 32'h04030201); chk("sw_men", m_en, 1'b1);
        drive(1, 8'h06, 0, 2'd1, 1); chk("sw_gap", m_valid, 1'b0);
        drive(0, 8'h00, 0, 2'd1, 1); chk("sw_grp2", lanes(), 32'h00000605); chk("sw_men2", m_en, 1'b1);

        // reset with a partial group and a full output stage
        for (int k = 1; k <= 6; k++) drive(1, 8'(k), 0, 2'd3, 0);
        drive(0, 8'h00, 0, 2'd3, 0);
        chk("rst_pre_busy", busy, 1'b1); chk("rst_pre_mval", m_valid, 1'b1);
        reset = 1'b1;
        drive(0, 8'h00, 0, 2'd3, 0);
        reset = 1'b0;
        chk("rst_mval", m_valid, 1'b0); chk("rst_busy", busy, 1'b0); chk("rst_srdy", s_ready, 1'b1);
        for (int k = 0; k < 4; k++) drive(1, 8'(8'h11 + k), 0, 2'd3, 1);
        drive(0, 8'h00, 0, 2'd3, 1);
        chk("rst_clean_grp", lanes(), 32'h14131211); chk("rst_clean_last", m_last, 1'b0);
        chk("rst_clean_men", m_en, 1'b1);
        drive(0, 8'h00, 0, 2'd3, 1);

        // random traffic against the group model
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            logic       rv, rl, rr;
            logic [1:0] rs;
            logic [7:0] rd;
            rv = (c < 1500) && ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 7) == 0);
            rr = (c >= 1500) || ($urandom_range(0, 9) < 6);
            rs = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            drive(rv, rd, rl, rs, rr);
            chk("rnd_srdy", s_ready, pend_l.size() < 2);
            chk("rnd_mval", m_valid, pend_l.size() > 0);
            chk("rnd_busy", busy, (pend_l.size() > 0) || (part_n > 0));
            chk("rnd_men", m_en, (pend_l.size() > 0) && m_ready);
            if (m_en) begin
                if (pend_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_extra_beat: got beat %h expected none", lanes());
                end else begin
                    chk("rnd_lanes", lanes(), pend_l.pop_front());
                    chk("rnd_last", m_last, pend_last.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                if (part_n == 0) part_spd = (int'(speed) > 3) ? 3 : int'(speed);
                part[part_n] = s_data;
                part_n++;
                if (part_n == part_spd + 1 || s_last) begin
                    exp_l = 32'h0;
                    for (int j = 0; j < part_n; j++) exp_l[j*8 +: 8] = part[j];
                    pend_l.push_back(exp_l);
                    pend_last.push_back(s_last);
                    part_n = 0;
                end
            end
        end
        chk("rnd_drained", pend_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_pack_feeder.md
Name: stream_pack_feeder

Overview:
- Upstream feeder for the flexible-speed operand stream register.
- Accepts a narrow valid/ready stream of WIDTH-bit words and packs 1..SPEED consecutive words into one lane vector, sized by the runtime speed setting.
- Delivers the vector with a single-cycle enable, so the downstream stream register advances by exactly speed+1 words per enable.
- Lane 0 carries the oldest word; lane speed carries the newest, which lands in downstream register 0.

Parameters:
- WIDTH, 8, data word width.
- SPEED, 4, maximum words per output beat (number of lanes).
- SPEED_LOG2, localparam, (SPEED==1) ? 1 : $clog2(SPEED); width of the speed config.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- speed  input  SPEED_LOG2  words per beat minus 1. Values above SPEED-1 are clamped to SPEED-1.
- s_data  input  WIDTH  input word.
- s_valid  input  1  input word valid.
- s_last  input  1  marks the final word of a tensor row; closes the current group.
- s_ready  output  1  block can accept s_data this cycle.
- m_data  output  [WIDTH-1:0] x [SPEED-1:0] (unpacked)  packed lane vector, drives the stream register's in[].
- m_valid  output  1  m_data holds a complete group.
- m_ready  input  1  downstream can advance this cycle.
- m_en  output  1  m_valid & m_ready; drives the stream register's en.
- m_last  output  1  current group was closed by s_last.
- busy  output  1  a partial group is being collected or m_valid is high.

Behaviour:
- Two storage stages:
  - Collect stage: lane buffer coll[SPEED], fill counter cnt, latched lane count spd_l, last flag.
  - Output stage: m_data register, m_valid, m_last.
- Input accept: acc = s_valid & s_ready.
- Collect FSM states:
  - FILL: coll has room.
  - HOLD: coll complete, waiting for the output stage.
- FILL behaviour:
  - s_ready = 1.
  - On acc with cnt==0: latch spd_l = clamp(speed).
  - On acc: coll[cnt] <= s_data.
  - Group completes when cnt == eff_spd or s_last is set. eff_spd is clamp(speed) if cnt==0, else spd_l.
  - On completion:
    - If the output stage is empty or m_en==1 in the same cycle: transfer to m_data the next cycle, reset cnt to 0, stay in FILL.
    - Otherwise go to HOLD.
  - Otherwise cnt <= cnt+1.
- HOLD behaviour: s_ready = 0. When the output stage is empty or m_en==1, transfer, set cnt=0, go to FILL.
- Transfer rules:
  - Lanes 0..(filled-1) copy coll.
  - Lanes above the completing word's index are written 0 (short group on s_last).
  - m_last <= group closed by s_last; m_valid <= 1.
- Output stage: m_valid clears on m_en unless a new transfer happens in the same cycle.
- Timing:
  - Latency: the word completing a group at cycle t gives m_valid=1 at t+1.
  - Throughput at speed=0: one beat per cycle with no bubbles while m_ready=1.
- Speed changes take effect only at a group boundary (cnt==0); mid-group changes are ignored.
- s_last on the first word gives a one-word group with lanes 1..SPEED-1 zeroed.
- m_ready held low: at most one complete group in coll plus one in m_data, then s_ready=0. No data loss, no duplication.
- m_data is stable while m_valid & !m_ready.
- Reset, including mid-operation, clears:
  - cnt=0, state=FILL, m_valid=0, m_last=0, busy=0, m_data=0, coll=0.
  - s_ready=1 in the first cycle after reset deasserts.
  - Any partial group is discarded.
- SPEED==1: speed is ignored; every accepted word forms a group.

Decomposition:
- Shared package stream_pkg holds:
  - the SPEED_LOG2 derivation as a function;
  - the collect FSM state enum (FILL, HOLD);
  - the clamp-speed function, also reusable by the stream register's config logic.
- One natural sub-module: stream_pack_lanebuf, the collect buffer plus counter, which emits a completed-group strobe and a lane mask. The top module holds the output stage and handshake.

Test Plan:
- SPEED=4, speed=3, m_ready=1, words 1..8 back-to-back.
  - Expected: m_data={1,2,3,4} at cycle 5, {5,6,7,8} at cycle 9.
  - m_en is high for exactly 2 cycles; s_ready stays 1 throughout.
- speed=0, words 0xA0..0xA5 back-to-back.
  - Expected: six consecutive m_en cycles, lane0 = 0xA0..0xA5, lanes 1..3 = 0.
- speed=2, words 10,11 then 12 with s_last.
  - Expected: m_data={10,11,12,0}, m_last=1.
  - Next group starts at cnt=0.
- speed=1, m_ready=0, feed 6 words.
  - Expected: s_ready drops after the 4th accepted word; m_data={1,2} stays stable.
  - Raising m_ready gives {1,2} then {3,4} with no loss.
  - Words 5,6 follow to give {5,6}.
- speed switched from 3 to 1 after 2 words of a group.
  - Expected: the group still completes at 4 words; the next group is 2 words.
- Reset asserted with cnt=2 and m_valid=1.
  - Expected: next cycle m_valid=0, busy=0, s_ready=1.
  - The following 4 words form a clean group {w0,w1,w2,w3} at speed=3.
